mixer_seq: RTL

Parametrised, time-multiplexed stereo audio mixer replacing the fixed-channel mixer. It feeds beeper/tape/AY/SD and future sources into the board's 1-bit DACs. The block walks through NCH unsigned channels one per clk28 cycle and applies independent 4-bit left and right gains to each, so panning and volume are set per channel. Each frame result is saturated and drives two first-order delta-sigma modulators.

---
 rtl/mixer_seq_if.sv | 29 ++
 rtl/mixer_seq.sv | 109 ++++++++++
 2 files changed

// File: rtl/mixer_seq_if.sv
// Mixer bus: per-channel samples and gains toward the mixer, mixed levels and
// delta-sigma bitstreams back from it.
interface mixer_seq_if #(
   parameter int NCH  = 12,
   parameter int SW   = 8,
   parameter int GW   = 4,
   parameter int DACW = 14
);
   logic [NCH*SW-1:0] ch_sample;
   logic [NCH*GW-1:0] gain_l;
   logic [NCH*GW-1:0] gain_r;
   logic              mono;
   logic              mute;
   logic [DACW-1:0]   level_l;
   logic [DACW-1:0]   level_r;
   logic              frame_stb;
   logic              dac_l;
   logic              dac_r;

   modport master (
      output ch_sample, gain_l, gain_r, mono, mute,
      input  level_l, level_r, frame_stb, dac_l, dac_r
   );

   modport slave (
      input  ch_sample, gain_l, gain_r, mono, mute,
      output level_l, level_r, frame_stb, dac_l, dac_r
   );
endinterface

// File: rtl/mixer_seq.sv
// Time-multiplexed stereo mixer: one channel per clk28 cycle, a latch cycle per
// frame, then saturated levels drive two first-order delta-sigma modulators.
module mixer_seq #(
   parameter int NCH   = 12,
   parameter int SW    = 8,
   parameter int GW    = 4,
   parameter int DACW  = 14,
   parameter int SHIFT = 2
) (
   input logic        clk28,
   input logic        rst_n,
   mixer_seq_if.slave bus
);
   localparam int IW = $clog2(NCH);
   localparam int PW = SW + GW;
   localparam int AW = PW + $clog2(NCH);
   localparam int XW = (AW > DACW) ? AW : DACW;
   localparam logic [XW-1:0] LMAX = XW'((1 << DACW) - 1);

   typedef enum logic {ACC, LATCH} state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   idx;
   logic [AW-1:0]   acc_l, acc_r;
   logic [SW-1:0]   sample;
   logic [GW-1:0]   gl, gr;
   logic [PW-1:0]   prod_l, prod_r;
   logic [XW-1:0]   sh_l, sh_r;
   logic [DACW-1:0] s_l, s_r;
   logic [DACW:0]   sum_lr;
   logic [DACW-1:0] mix_l, mix_r;
   logic [DACW-1:0] level_l, level_r;
   logic            frame_stb;
   logic [DACW:0]   cnt_l, cnt_r;

   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) state <= ACC;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ACC:   if (idx == IW'(NCH - 1)) state_nx = LATCH;
         LATCH: state_nx = ACC;
      endcase
   end

   always_comb begin
      sample = bus.ch_sample[idx*SW +: SW];
      gl     = bus.gain_l[idx*GW +: GW];
      gr     = bus.gain_r[idx*GW +: GW];
      prod_l = PW'(sample) * PW'(gl);
      prod_r = PW'(sample) * PW'(gr);

      // Widen before shifting so saturation also works when DACW > AW
      sh_l = XW'(acc_l) >> SHIFT;
      sh_r = XW'(acc_r) >> SHIFT;
      s_l  = (sh_l > LMAX) ? DACW'(LMAX) : sh_l[DACW-1:0];
      s_r  = (sh_r > LMAX) ? DACW'(LMAX) : sh_r[DACW-1:0];

      sum_lr = {1'b0, s_l} + {1'b0, s_r};
      mix_l  = s_l;
      mix_r  = s_r;
      if (bus.mute) begin
         mix_l = '0;
         mix_r = '0;
      end else if (bus.mono) begin
         mix_l = DACW'(sum_lr >> 1);
         mix_r = DACW'(sum_lr >> 1);
      end
   end

   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         acc_l     <= '0;
         acc_r     <= '0;
         level_l   <= '0;
         level_r   <= '0;
         frame_stb <= 1'b0;
         cnt_l     <= '0;
         cnt_r     <= '0;
      end else begin
         frame_stb <= 1'b0;
         // Modulators free-run; the carry out of the low DACW bits is the bitstream
         cnt_l <= {1'b0, cnt_l[DACW-1:0]} + {1'b0, level_l};
         cnt_r <= {1'b0, cnt_r[DACW-1:0]} + {1'b0, level_r};
         if (state == LATCH) begin
            level_l   <= mix_l;
            level_r   <= mix_r;
            frame_stb <= 1'b1;
            acc_l     <= '0;
            acc_r     <= '0;
            idx       <= '0;
         end else begin
            acc_l <= acc_l + AW'(prod_l);
            acc_r <= acc_r + AW'(prod_r);
            idx   <= (idx == IW'(NCH - 1)) ? '0 : idx + 1'b1;
         end
      end
   end

   assign bus.level_l   = level_l;
   assign bus.level_r   = level_r;
   assign bus.frame_stb = frame_stb;
   assign bus.dac_l     = cnt_l[DACW];
   assign bus.dac_r     = cnt_r[DACW];
endmodule
